// File: rtl/accumulator_datapath.sv
// Accumulator-side datapath: AC/R registers, single-cycle ALU, zero flag and saturating op counter.
// Optional macro ALU_CARRY_EN adds the registered carry/shift-out flag c_flag.
module accumulator_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [13:0]       signals,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              flag,
    output logic [CNT_W-1:0]  op_count
`ifdef ALU_CARRY_EN
    ,
    output logic              c_flag
`endif
);

    localparam int unsigned EXT_W = DATA_W + 1;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_RSH = 3'b100;
    localparam logic [2:0] OP_LSH = 3'b101;

    logic [2:0]        alu_op;
    logic              ac_clear;
    logic              ac_load;
    logic              r_load;
    logic              alu_en;
    logic              alu_valid;
    logic [DATA_W-1:0] ac;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] ac_next;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;

    assign alu_op   = signals[2:0];
    assign ac_clear = signals[3];
    assign ac_load  = signals[6];
    assign r_load   = signals[10];
    assign alu_en   = signals[11];

    assign bus_oe   = signals[5];
    assign bus_out  = ac;

    // ALU result and carry/borrow/shift-out for the current opcode
    always_comb begin
        alu_res   = ac;
        alu_carry = 1'b0;
        alu_valid = 1'b0;
        case (alu_op)
            OP_ADD: begin
                {alu_carry, alu_res} = EXT_W'(ac) + EXT_W'(r);
                alu_valid = alu_en;
            end
            OP_SUB: begin
                {alu_carry, alu_res} = EXT_W'(ac) - EXT_W'(r);
                alu_valid = alu_en;
            end
            OP_INC: begin
                {alu_carry, alu_res} = EXT_W'(ac) + EXT_W'(1);
                alu_valid = alu_en;
            end
            OP_RSH: begin
                alu_res   = ac >> 1;
                alu_carry = ac[0];
                alu_valid = alu_en;
            end
            OP_LSH: begin
                alu_res   = ac << 1;
                alu_carry = ac[DATA_W-1];
                alu_valid = alu_en;
            end
            default: begin
                alu_res   = ac;
                alu_carry = 1'b0;
                alu_valid = 1'b0;
            end
        endcase
    end

    // AC update priority: clear, then load, then ALU, else hold
    always_comb begin
        ac_next = ac;
        if (ac_clear) begin
            ac_next = '0;
        end else if (ac_load) begin
            ac_next = bus_in;
        end else if (alu_valid) begin
            ac_next = alu_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac       <= '0;
            r        <= '0;
            flag     <= 1'b1;
            op_count <= '0;
        end else begin
            ac   <= ac_next;
            flag <= (ac_next == '0);
            if (r_load) begin
                r <= bus_in;
            end
            // Counts every valid ALU request, even when clear/load overrides the AC result
            if (alu_valid && (op_count != '1)) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

`ifdef ALU_CARRY_EN
    // Carry only moves when the ALU result actually lands in AC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_flag <= 1'b0;
        end else if (alu_valid && !ac_clear && !ac_load) begin
            c_flag <= alu_carry;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{signals[13:12], signals[9:7], signals[4]};
`else
    logic unused_bits;
    assign unused_bits = ^{signals[13:12], signals[9:7], signals[4], alu_carry};
`endif

endmodule

// File: tb/tb_accumulator_datapath.sv
// Scoreboard bench for accumulator_datapath: directed scenarios plus random commands vs. a behavioural model.
module tb_accumulator_datapath;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int          AC_MAX = (1 << DATA_W) - 1;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [13:0]       signals;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              flag;
    logic [CNT_W-1:0]  op_count;
`ifdef ALU_CARRY_EN
    logic              c_flag;
`endif

    accumulator_datapath #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .signals  (signals),
        .bus_in   (bus_in),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .flag     (flag),
        .op_count (op_count)
`ifdef ALU_CARRY_EN
        ,
        .c_flag   (c_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ac;
        int flg;
        int cnt;
        int c;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Behavioural model state
    int m_ac, m_r, m_cnt, m_c;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [13:0] mk(input int op, input bit clr, input bit drv,
                                       input bit ld, input bit rld, input bit en);
        logic [13:0] w;
        w = '0;
        w[2:0] = 3'(op);
        w[3]   = clr;
        w[5]   = drv;
        w[6]   = ld;
        w[10]  = rld;
        w[11]  = en;
        return w;
    endfunction

    task automatic model_reset();
        m_ac = 0; m_r = 0; m_cnt = 0; m_c = 0;
    endtask

    // Apply one control word to the model, straight from the arithmetic rules
    task automatic model_step(input logic [13:0] w, input int bus);
        int  op, res, car;
        bit  valid;
        op    = int'(w[2:0]);
        valid = w[11] && (op >= 1) && (op <= 5);
        res   = m_ac;
        car   = 0;
        case (op)
            1: begin res = (m_ac + m_r) % (AC_MAX + 1); car = (m_ac + m_r > AC_MAX) ? 1 : 0; end
            2: begin res = (m_ac - m_r + AC_MAX + 1) % (AC_MAX + 1); car = (m_ac < m_r) ? 1 : 0; end
            3: begin res = (m_ac + 1) % (AC_MAX + 1); car = (m_ac == AC_MAX) ? 1 : 0; end
            4: begin res = m_ac / 2; car = m_ac % 2; end
            5: begin res = (m_ac * 2) % (AC_MAX + 1); car = (m_ac > AC_MAX / 2) ? 1 : 0; end
            default: ;
        endcase
        if (valid && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        if (w[3]) m_ac = 0;
        else if (w[6]) m_ac = bus;
        else if (valid) begin
            m_ac = res;
            m_c  = car;
        end
        if (w[10]) m_r = bus;
    endtask

    // Drive one command for the next rising edge and queue its expected outcome
    task automatic issue(input logic [13:0] w, input int bus);
        exp_t e;
        @(negedge clk);
        signals = w;
        bus_in  = DATA_W'(bus);
        model_step(w, bus);
        e.ac = m_ac; e.flg = (m_ac == 0) ? 1 : 0; e.cnt = m_cnt; e.c = m_c;
        exp_q.push_back(e);
        #1;
        chk("bus_oe", int'(bus_oe), int'(w[5]));
    endtask

    // Monitor: every edge that consumed a command is compared against the queue head
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ac", int'(bus_out), e.ac);
            chk("flag", int'(flag), e.flg);
            chk("op_count", int'(op_count), e.cnt);
`ifdef ALU_CARRY_EN
            chk("c_flag", int'(c_flag), e.c);
`endif
        end
    end

    task automatic mid_cycle_reset();
        @(negedge clk);
        signals = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_ac", int'(bus_out), 0);
        chk("rst_flag", int'(flag), 1);
        chk("rst_cnt", int'(op_count), 0);
`ifdef ALU_CARRY_EN
        chk("rst_c", int'(c_flag), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [13:0] rw;

    initial begin
        rst     = 1'b1;
        signals = 14'h020;
        bus_in  = '0;
        model_reset();
        #2;
        chk("init_ac", int'(bus_out), 0);
        chk("init_flag", int'(flag), 1);
        chk("init_cnt", int'(op_count), 0);
        chk("init_oe", int'(bus_oe), 1);
        signals = '0;
        #1;
        chk("init_oe0", int'(bus_oe), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Load R and AC, then ADD
        issue(mk(0, 0, 0, 0, 1, 0), 'h30);
        issue(mk(0, 0, 1, 1, 0, 0), 'h12);
        issue(mk(1, 0, 0, 0, 0, 1), 'h00);
        // Wrap-around on INC and SUB
        issue(mk(0, 0, 0, 1, 0, 0), 'hFF);
        issue(mk(3, 0, 0, 0, 0, 1), 'h00);
        issue(mk(0, 0, 0, 0, 1, 0), 'h01);
        issue(mk(2, 0, 1, 0, 0, 1), 'h00);
        // Shifts
        issue(mk(0, 0, 0, 1, 0, 0), 'h81);
        issue(mk(4, 0, 0, 0, 0, 1), 'h00);
        issue(mk(5, 0, 0, 0, 0, 1), 'h00);
        issue(mk(5, 0, 0, 0, 0, 1), 'h00);
        // Priority, including r_load using old R alongside ADD
        issue(mk(1, 1, 0, 1, 0, 1), 'h77);
        issue(mk(1, 0, 0, 1, 0, 1), 'h3C);
        issue(mk(1, 0, 0, 0, 1, 1), 'h05);
        // Held INC repeats, illegal codes do nothing
        for (int i = 0; i < 3; i++) issue(mk(3, 0, 0, 0, 0, 1), 'h00);
        issue(mk(6, 0, 0, 0, 0, 1), 'hAA);
        issue(mk(7, 0, 0, 0, 0, 1), 'hAA);
        issue(mk(0, 0, 0, 0, 0, 1), 'hAA);
        // Counter saturation
        for (int i = 0; i < 20; i++) issue(mk(3, 0, i[0], 0, 0, 1), 'h00);

        // Mid-cycle reset with AC=0x5A, then show R cleared
        issue(mk(0, 0, 0, 1, 1, 0), 'h5A);
        mid_cycle_reset();
        issue(mk(0, 0, 0, 1, 0, 0), 'h05);
        issue(mk(1, 0, 0, 0, 0, 1), 'h00);

        // Randomized commands
        for (int i = 0; i < 300; i++) begin
            rw = 14'($urandom);
            if ($urandom_range(7) != 0) rw[3] = 1'b0;
            if ($urandom_range(3) != 0) rw[6] = 1'b0;
            if ($urandom_range(3) == 0) rw[11] = 1'b1;
            issue(rw, int'($urandom_range(AC_MAX)));
        end

        @(negedge clk);
        signals = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
